reg_display_ctrl: RTL and testbench

Display-side controller for the pipelined MIPS core's register debug port. It drives the register index into the datapath's display read port and consumes the returned 32-bit value. It also debounces two push buttons to step the index, and time-multiplexes the value, or the next PC, onto an 8-digit active-low seven-segment display. It sits at board top level between the core and the display pins.

---
 rtl/reg_display_ctrl.sv | 138 +++++++++++++
 tb/tb_reg_display_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_display_ctrl.sv
// Register-debug display controller: debounced buttons step the register index,
// and the selected value (or the next PC) is scanned onto an 8-digit seven-segment display.
module reg_display_ctrl #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        BtnNext,
  input  logic        BtnPrev,
  input  logic        ShowPC,
  input  logic [31:0] PCNext,
  input  logic [31:0] DispRegData,
  output logic [4:0]  DispReadReg,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Bit 0 is the Next button, bit 1 the Prev button throughout.
  logic [1:0]       w_raw;
  logic [1:0]       r_sync_a;
  logic [1:0]       r_sync_b;
  logic [1:0]       r_level;
  logic [1:0]       r_level_d;
  logic [1:0]       r_pulse;
  logic [DEB_W-1:0] r_deb_cnt [2];

  assign w_raw = {BtnPrev, BtnNext};

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_sync_a     <= '0;
      r_sync_b     <= '0;
      r_level      <= '0;
      r_level_d    <= '0;
      r_pulse      <= '0;
      r_deb_cnt[0] <= '0;
      r_deb_cnt[1] <= '0;
    end else begin
      r_sync_a  <= w_raw;
      r_sync_b  <= r_sync_a;
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      for (int b = 0; b < 2; b++) begin
        if (r_sync_b[b] == r_level[b]) begin
          r_deb_cnt[b] <= '0;
        end else if (r_deb_cnt[b] == DEB_LAST) begin
          r_level[b]   <= ~r_level[b];
          r_deb_cnt[b] <= '0;
        end else begin
          r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  logic [4:0] r_index;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_index <= '0;
    end else begin
      case (r_pulse)
        2'b01:   r_index <= r_index + 5'd1;
        2'b10:   r_index <= r_index - 5'd1;
        default: r_index <= r_index;
      endcase
    end
  end

  assign DispReadReg = r_index;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_digit;
  logic [31:0]      r_snap;
  logic             w_div_tc;
  logic [31:0]      w_src;
  logic [3:0]       w_nibble;

  assign w_div_tc = (r_div == DIV_LAST);
  assign w_src    = ShowPC ? PCNext : DispRegData;
  assign w_nibble = r_snap[{r_digit, 2'b00} +: 4];

  // The snapshot only reloads as digit 7 hands over to digit 0, so a frame never tears.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_div   <= '0;
      r_digit <= '0;
      r_snap  <= '0;
      AN      <= 8'b1111_1110;
      SEG     <= 7'b1000000;
      DP      <= 1'b1;
    end else begin
      if (w_div_tc) begin
        r_div   <= '0;
        r_digit <= r_digit + 3'd1;
        if (r_digit == 3'd7) begin
          r_snap <= w_src;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
      AN  <= ~(8'b0000_0001 << r_digit);
      SEG <= hex7(w_nibble);
      DP  <= ~((r_digit == 3'd7) && ShowPC);
    end
  end

endmodule

// File: tb/tb_reg_display_ctrl.sv
// Randomized scoreboard bench for reg_display_ctrl: a time-based reference model
// predicts digit scans and index steps; monitors compare whenever the DUT outputs change.
module tb_reg_display_ctrl;

  localparam int RDIV = 4;
  localparam int DEB  = 3;

  logic        clk = 1'b0;
  logic        Reset;
  logic        BtnNext;
  logic        BtnPrev;
  logic        ShowPC;
  logic [31:0] PCNext;
  logic [31:0] DispRegData;
  logic [4:0]  DispReadReg;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  always #5 clk = ~clk;

  reg_display_ctrl #(.REFRESH_DIV(RDIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK        (clk),
    .Reset      (Reset),
    .BtnNext    (BtnNext),
    .BtnPrev    (BtnPrev),
    .ShowPC     (ShowPC),
    .PCNext     (PCNext),
    .DispRegData(DispRegData),
    .DispReadReg(DispReadReg),
    .AN         (AN),
    .SEG        (SEG),
    .DP         (DP)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         n;
  } disp_t;

  typedef struct {
    logic [4:0] idx;
    int         n;
  } idx_t;

  logic [6:0] hex_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  disp_t      disp_q [$];
  idx_t       idx_q  [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         since_rst = 0;
  logic [31:0] model_snap = '0;
  logic [4:0]  model_idx = '0;
  bit          mon_en = 1'b0;
  logic [7:0]  prev_an;
  logic [4:0]  prev_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: edge n after reset release shows slot (n-1)/4 of the scan;
  // each 32-edge frame displays the source value seen at the frame's opening edge.
  always @(posedge clk) begin
    cyc++;
    if (Reset) begin
      since_rst  = 0;
      model_snap = '0;
      disp_q.delete();
    end else begin
      since_rst++;
      if (since_rst % (8 * RDIV) == 0) model_snap = ShowPC ? PCNext : DispRegData;
      if (since_rst > RDIV && (since_rst - 1) % RDIV == 0) begin
        disp_t e;
        int    d;
        logic [31:0] sh;
        d     = ((since_rst - 1) / RDIV) % 8;
        sh    = model_snap >> (4 * d);
        e.an  = ~(8'd1 << d);
        e.seg = hex_tbl[sh[3:0]];
        e.dp  = !(d == 7 && ShowPC);
        e.n   = since_rst;
        disp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("an_onehot_dp", {63'd0, ($countones(~AN) == 1) && (DP || AN == 8'h7F)}, 64'd1);
      if (AN !== prev_an) begin
        if (disp_q.size() == 0) begin
          check("disp_unexpected", {56'd0, AN}, {56'd0, prev_an});
        end else begin
          disp_t e;
          e = disp_q.pop_front();
          check("disp_an",   {56'd0, AN},  {56'd0, e.an});
          check("disp_seg",  {57'd0, SEG}, {57'd0, e.seg});
          check("disp_dp",   {63'd0, DP},  {63'd0, e.dp});
          check("disp_edge", 64'(since_rst), 64'(e.n));
        end
      end
      if (DispReadReg !== prev_idx) begin
        if (idx_q.size() == 0) begin
          check("idx_unexpected", {59'd0, DispReadReg}, {59'd0, prev_idx});
        end else begin
          idx_t x;
          x = idx_q.pop_front();
          check("idx_value", {59'd0, DispReadReg}, {59'd0, x.idx});
          check("idx_edge",  64'(cyc), 64'(x.n));
        end
      end
    end
    prev_an  = AN;
    prev_idx = DispReadReg;
  end

  // A press held for h sampled cycles is accepted when h >= DEB; a single-button
  // acceptance steps the index 6 edges after the first sampled high.
  task automatic press(input logic nxt, input logic prv, input int h);
    int e0;
    @(negedge clk);
    BtnNext = nxt;
    BtnPrev = prv;
    e0 = cyc + 1;
    if (h >= DEB && (nxt ^ prv)) begin
      idx_t x;
      model_idx = nxt ? 5'((int'(model_idx) + 1) % 32) : 5'((int'(model_idx) + 31) % 32);
      x.idx = model_idx;
      x.n   = e0 + DEB + 3;
      idx_q.push_back(x);
    end
    repeat (h) @(negedge clk);
    BtnNext = 1'b0;
    BtnPrev = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    Reset = 1'b1; BtnNext = 1'b0; BtnPrev = 1'b0; ShowPC = 1'b0;
    PCNext = '0; DispRegData = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    check("rst_an",  {56'd0, AN},          64'hFE);
    check("rst_seg", {57'd0, SEG},         64'h40);
    check("rst_dp",  {63'd0, DP},          64'd1);
    check("rst_idx", {59'd0, DispReadReg}, 64'd0);
    mon_en = 1'b1;

    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 1);
    check("glitch_idx", {59'd0, DispReadReg}, {59'd0, model_idx});
    press(1'b0, 1'b1, 5);
    press(1'b0, 1'b1, 5);
    check("wrap_down", {59'd0, DispReadReg}, 64'd31);
    press(1'b1, 1'b0, 5);
    check("wrap_up", {59'd0, DispReadReg}, 64'd0);
    press(1'b1, 1'b1, 6);
    check("both_idx", {59'd0, DispReadReg}, 64'd0);

    DispRegData = 32'h1234ABCD;
    repeat (64) @(negedge clk);
    ShowPC = 1'b1;
    PCNext = 32'h00400008;
    repeat (64) @(negedge clk);
    ShowPC = 1'b0;
    repeat (13) @(negedge clk);
    DispRegData = 32'hCAFEF00D;
    repeat (50) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) DispRegData = $urandom;
      if ($urandom_range(0, 1) == 1) PCNext = $urandom;
      if ($urandom_range(0, 3) == 0) ShowPC = ~ShowPC;
      case (op)
        0:       press(1'b1, 1'b0, $urandom_range(1, 8));
        1:       press(1'b0, 1'b1, $urandom_range(1, 8));
        2:       press(1'b1, 1'b1, $urandom_range(DEB, 8));
        default: if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0, $urandom_range(1, DEB - 1));
                 else press(1'b0, 1'b1, $urandom_range(1, DEB - 1));
      endcase
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("idx_q_empty",  64'(idx_q.size()),  64'd0);
    check("disp_q_empty", 64'(disp_q.size()), 64'd0);
    check("idx_final", {59'd0, DispReadReg}, {59'd0, model_idx});

    // Reset in the middle of an accepted-but-not-yet-pulsed press must discard it.
    mon_en = 1'b0;
    ShowPC = 1'b1;
    BtnNext = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    BtnNext = 1'b0;
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("midrst_an",  {56'd0, AN},          64'hFE);
    check("midrst_seg", {57'd0, SEG},         64'h40);
    check("midrst_dp",  {63'd0, DP},          64'd1);
    check("midrst_idx", {59'd0, DispReadReg}, 64'd0);
    repeat (12) @(negedge clk);
    check("midrst_discard", {59'd0, DispReadReg}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
